shift_out_serial_8bit: RTL

SHIFT_OUT_SERIAL_8BIT -- requirements
Module: shift_out_serial_8bit

---
 rtl/shift_out_serial_8bit_pkg.sv | 17 +
 rtl/shift_out_serial_8bit_bit_timer.sv | 29 ++
 rtl/shift_out_serial_8bit.sv | 103 ++++++++++
 3 files changed

// File: rtl/shift_out_serial_8bit_pkg.sv
// Shared definitions for the serial byte shifter: FSM state encodings and default bit timing.
`ifndef SHIFT_OUT_SERIAL_8BIT_PKG_SV
`define SHIFT_OUT_SERIAL_8BIT_PKG_SV
package shift_out_serial_8bit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int CLKS_PER_BIT_DEFAULT = 4;
  localparam int NUM_DATA_BITS        = 8;

endpackage
`endif

// File: rtl/shift_out_serial_8bit_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 on the falling edge, tick marks the terminal count.
module bit_timer
  import shift_out_serial_8bit_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic Clkbar,
  input  logic Clrbar,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt;

  always_ff @(negedge Clkbar or negedge Clrbar) begin
    if (!Clrbar) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/shift_out_serial_8bit.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, stop bit; line idles high.
module shift_out_serial_8bit
  import shift_out_serial_8bit_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       Clkbar,
  input  logic       Clrbar,
  input  logic [7:0] in,
  input  logic       Ldbar,
  output logic       Sout,
  output logic       Busy,
  output logic       Done
);

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] bit_idx, bit_idx_nxt;
  logic       sout_nxt, busy_nxt, done_nxt;
  logic       restart, tick;

  // Timer is held at zero while idle so the load edge starts a clean start-bit period.
  assign restart = (state == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clkbar (Clkbar),
    .Clrbar (Clrbar),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    sout_nxt    = Sout;
    busy_nxt    = Busy;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        sout_nxt = 1'b1;
        busy_nxt = 1'b0;
        if (!Ldbar) begin
          shreg_nxt = in;
          state_nxt = START;
          sout_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_nxt   = DATA;
          sout_nxt    = shreg[0];
          shreg_nxt   = {1'b0, shreg[7:1]};
          bit_idx_nxt = 4'd0;
        end
      end
      DATA: begin
        // bit_idx names the bit currently on the line; the last one hands over to the stop bit.
        if (tick) begin
          if (bit_idx == 4'(NUM_DATA_BITS - 1)) begin
            state_nxt   = STOP;
            sout_nxt    = 1'b1;
            bit_idx_nxt = 4'd0;
          end else begin
            sout_nxt    = shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge Clkbar or negedge Clrbar) begin
    if (!Clrbar) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      Sout    <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      Sout    <= sout_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
    end
  end

endmodule
